// File: rtl/avalon_lsu_master.sv
// avalon_lsu_master: single-outstanding load/store master for a fixed-latency,
// no-waitrequest Avalon-MM RAM slave. Generates byteenables, replicates store
// lanes, extracts and sign/zero-extends load lanes.
// Optional feature macro: LSU_MISALIGN_ERR_EN
//   defined   -> misaligned requests skip the bus and return rsp_err=1
//   undefined -> misaligned requests are forced to alignment, rsp_err=0
module avalon_lsu_master #(
  parameter int ADDR_W       = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic [3:0]        avm_be_q, avm_be_d;
  logic              avm_cs_q, avm_cs_d;
  logic              avm_we_q, avm_we_d;
  logic [31:0]       avm_wd_q, avm_wd_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]  a_lo;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [15:0] rd_shift;
  logic [31:0] rd_ext;
  logic        unused_addr_bits;

  // Address bits above the RAM window are dropped, so accesses wrap.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Request decode: aligned lane offset, lane enables, replicated store data.
  always_comb begin
    a_lo   = req_addr[1:0];
    be     = 4'b1111;
    wd_rep = req_wdata;
    case (req_size)
      2'b00: begin
        be     = 4'b0001 << req_addr[1:0];
        wd_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        a_lo   = {req_addr[1], 1'b0};
        be     = 4'b0011 << {req_addr[1], 1'b0};
        wd_rep = {2{req_wdata[15:0]}};
      end
      default: a_lo = 2'b00;
    endcase
  end

  // Load path: move the addressed lane to bit 0 and extend it.
  always_comb begin
    rd_shift = 16'(avm_readdata >> {addr_lo_q, 3'b000});
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = uns_q ? {16'h0, rd_shift} : {{16{rd_shift[15]}}, rd_shift};
      default: rd_ext = avm_readdata;
    endcase
  end

  // Next-state logic; bus strobes default low so they pulse for one cycle.
  always_comb begin
    state_d       = state_q;
    avm_address_d = avm_address_q;
    avm_be_d      = avm_be_q;
    avm_cs_d      = 1'b0;
    avm_we_d      = 1'b0;
    avm_wd_d      = avm_wd_q;
    addr_lo_d     = addr_lo_q;
    size_d        = size_q;
    uns_d         = uns_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_ERR_EN
          if ((req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00)) begin
            state_d     = S_RESP;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
          end else
`endif
          begin
            state_d       = S_BUS;
            avm_cs_d      = 1'b1;
            avm_we_d      = req_we;
            avm_address_d = req_addr[ADDR_W+1:2];
            avm_be_d      = be;
            avm_wd_d      = wd_rep;
            addr_lo_d     = a_lo;
            size_d        = req_size;
            uns_d         = req_unsigned;
          end
        end
      end
      S_BUS: begin
        if (avm_we_q) begin
          state_d     = S_RESP;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 2'(READ_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = S_RESP;
          rsp_rdata_d = rd_ext;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      avm_address_q <= '0;
      avm_be_q      <= '0;
      avm_cs_q      <= 1'b0;
      avm_we_q      <= 1'b0;
      avm_wd_q      <= '0;
      addr_lo_q     <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      avm_address_q <= avm_address_d;
      avm_be_q      <= avm_be_d;
      avm_cs_q      <= avm_cs_d;
      avm_we_q      <= avm_we_d;
      avm_wd_q      <= avm_wd_d;
      addr_lo_q     <= addr_lo_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_rdata      = rsp_rdata_q;
`ifdef LSU_MISALIGN_ERR_EN
  assign rsp_err        = rsp_err_q;
`else
  assign rsp_err        = 1'b0;
`endif
  assign avm_address    = avm_address_q;
  assign avm_byteenable = avm_be_q;
  assign avm_chipselect = avm_cs_q;
  assign avm_write      = avm_we_q;
  assign avm_writedata  = avm_wd_q;

endmodule
